// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, microsecond-to-cycle conversion and
// common mouse command bytes. Used by both the transmit and receive directions.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    WAIT_IDLE,
    DONE,
    ERR
  } ps2_state_t;

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;

  // 64-bit math: 50 MHz * 15000 us overflows 32 bits before the divide.
  function automatic longint unsigned us_to_cyc(input longint unsigned clk_hz,
                                                input longint unsigned us);
    return (clk_hz * us) / 64'd1000000;
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser followed by a stability filter for one open-drain PS/2 line.
// Emits the accepted level and a one-cycle strobe when that level goes 1->0.
module ps2_sync_filter #(
  parameter int unsigned FILT_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic          s1_reg;
  logic          s2_reg;
  logic          level_reg;
  logic          fall_reg;
  logic [CW-1:0] cnt_reg;

  // Lines idle high through the pull-ups, so everything resets to the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg    <= 1'b1;
      s2_reg    <= 1'b1;
      level_reg <= 1'b1;
      fall_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      s1_reg   <= din;
      s2_reg   <= s1_reg;
      fall_reg <= 1'b0;
      if (s2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(FILT_LEN - 1)) begin
        level_reg <= s2_reg;
        fall_reg  <= level_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign level = level_reg;
  assign fall  = fall_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send and shifts
// one command byte plus odd parity out on device clock falls, then checks the ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned INHIBIT_US  = 120,
  parameter int unsigned START_TO_US = 15000,
  parameter int unsigned FRAME_TO_US = 2000,
  parameter int unsigned FILT_LEN    = 8
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam longint unsigned INH_CYC   = us_to_cyc(64'(CLK_HZ), 64'(INHIBIT_US));
  localparam longint unsigned START_CYC = us_to_cyc(64'(CLK_HZ), 64'(START_TO_US));
  localparam longint unsigned FRAME_CYC = us_to_cyc(64'(CLK_HZ), 64'(FRAME_TO_US));
  localparam longint unsigned MAX_CYC =
      (INH_CYC > START_CYC) ? ((INH_CYC > FRAME_CYC) ? INH_CYC : FRAME_CYC)
                            : ((START_CYC > FRAME_CYC) ? START_CYC : FRAME_CYC);
  localparam int TW = (MAX_CYC > 64'd1) ? $clog2(MAX_CYC) : 1;

  // The timer counts down to zero, so loads are one less than the interval length.
  localparam logic [TW-1:0] INH_LOAD   = TW'(INH_CYC - 64'd1);
  localparam logic [TW-1:0] START_LOAD = TW'(START_CYC - 64'd1);
  localparam logic [TW-1:0] FRAME_LOAD = TW'(FRAME_CYC - 64'd1);

  ps2_state_t    state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [8:0]    sr_reg, sr_next;
  logic [3:0]    bitcnt_reg, bitcnt_next;

  logic [1:0] line_pad;
  logic [1:0] line_level;
  logic [1:0] line_fall;
  logic       clk_level;
  logic       clk_fall;
  logic       dat_level;
  logic       unused_dat_fall;
  logic       timeout;

  // Index 0 is the clock line, index 1 the data line.
  assign line_pad = {ps2_dat_i, ps2_clk_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_line
    ps2_sync_filter #(
      .FILT_LEN(FILT_LEN)
    ) u_filt (
      .clk  (clk_clk),
      .rst_n(reset_reset_n),
      .din  (line_pad[gi]),
      .level(line_level[gi]),
      .fall (line_fall[gi])
    );
  end

  assign clk_level       = line_level[0];
  assign clk_fall        = line_fall[0];
  assign dat_level       = line_level[1];
  assign unused_dat_fall = line_fall[1];
  assign timeout         = (timer_reg == '0);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_reg  <= IDLE;
      timer_reg  <= '0;
      sr_reg     <= '0;
      bitcnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      timer_reg  <= timer_next;
      sr_reg     <= sr_next;
      bitcnt_reg <= bitcnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    timer_next  = timer_reg;
    sr_next     = sr_reg;
    bitcnt_next = bitcnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (tx_valid) begin
          sr_next     = {~^tx_data, tx_data};
          timer_next  = INH_LOAD;
          bitcnt_next = '0;
          state_next  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (timeout) begin
          timer_next = START_LOAD;
          state_next = RTS;
        end else begin
          timer_next = timer_reg - TW'(1);
        end
      end
      RTS: begin
        if (timeout) begin
          state_next = ERR;
        end else if (clk_fall) begin
          timer_next  = FRAME_LOAD;
          bitcnt_next = '0;
          state_next  = SHIFT;
        end else begin
          timer_next = timer_reg - TW'(1);
        end
      end
      SHIFT: begin
        if (timeout) begin
          state_next = ERR;
        end else begin
          timer_next = timer_reg - TW'(1);
          // The fall after parity releases data for the stop bit.
          if (clk_fall) begin
            if (bitcnt_reg == 4'd8) state_next = ACK;
            else bitcnt_next = bitcnt_reg + 4'd1;
          end
        end
      end
      ACK: begin
        if (timeout) begin
          state_next = ERR;
        end else begin
          timer_next = timer_reg - TW'(1);
          if (clk_fall) state_next = dat_level ? ERR : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (timeout) begin
          state_next = ERR;
        end else begin
          timer_next = timer_reg - TW'(1);
          if (clk_level && dat_level) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Decoded straight from state so an asynchronous reset releases both lines at once.
  always_comb begin
    tx_ready   = (state_reg == IDLE);
    tx_busy    = (state_reg != IDLE);
    tx_done    = (state_reg == DONE);
    tx_error   = (state_reg == ERR);
    ps2_clk_oe = (state_reg == INHIBIT);
    ps2_dat_oe = 1'b0;
    if (state_reg == RTS)   ps2_dat_oe = 1'b1;
    if (state_reg == SHIFT) ps2_dat_oe = ~sr_reg[bitcnt_reg];
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model on pulled-up lines captures each frame on
// its clock rising edges; a queue of expected frames/outcomes scores every transfer.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int M_NORMAL = 0;
  localparam int M_NOCLK  = 1;
  localparam int M_NACK   = 2;
  localparam int M_GLITCH = 3;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx_error;
  logic       ps2_clk_oe, ps2_dat_oe, ps2_clk_i, ps2_dat_i;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       glitch = 1'b0;
  logic       clk_line, dat_line;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int clk_oe_cnt = 0;

  typedef struct {
    logic [10:0] frame;
    int          n_done;
    int          n_err;
  } exp_t;
  exp_t exp_q[$];

  assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign dat_line  = ~(ps2_dat_oe | dev_dat_low);
  assign ps2_clk_i = clk_line & ~glitch;
  assign ps2_dat_i = dat_line;

  always #500 clk_clk = ~clk_clk;

  ps2_host_tx #(
    .CLK_HZ(1_000_000)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .tx_error     (tx_error),
    .ps2_clk_i    (ps2_clk_i),
    .ps2_dat_i    (ps2_dat_i),
    .ps2_clk_oe   (ps2_clk_oe),
    .ps2_dat_oe   (ps2_dat_oe)
  );

  always @(negedge clk_clk) begin
    if (tx_done)    done_cnt <= done_cnt + 1;
    if (tx_error)   err_cnt <= err_cnt + 1;
    if (ps2_clk_oe) clk_oe_cnt <= clk_oe_cnt + 1;
  end

  // Frame as the device sees it: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    int   ones;
    logic par;
    ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    par = ((ones % 2) == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] d, input int nd, input int ne);
    exp_t e;
    e.frame  = frame_of(d);
    e.n_done = nd;
    e.n_err  = ne;
    exp_q.push_back(e);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk_clk);
    tx_valid = 1'b0;
  endtask

  // Device side: ~12 kHz clock (40 us half periods at 1 MHz), samples data on rising edges.
  task automatic device_receive(input int mode, input int abort_pulse,
                                output logic [10:0] frame, output int inh_len,
                                output bit rts_seen);
    int t;
    frame    = '1;
    inh_len  = 0;
    rts_seen = 1'b0;
    t = 0;
    while (clk_line && t < 100) begin @(negedge clk_clk); t++; end
    while (!clk_line && inh_len < 2000) begin @(negedge clk_clk); inh_len++; end
    t = 0;
    while (dat_line && t < 50) begin @(negedge clk_clk); t++; end
    rts_seen = (!dat_line && clk_line);
    if (!rts_seen || mode == M_NOCLK) return;
    repeat (20) @(negedge clk_clk);
    frame[0] = dat_line;
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (20) @(negedge clk_clk);
      if (i == abort_pulse) return;
      repeat (20) @(negedge clk_clk);
      dev_clk_low = 1'b0;
      frame[i] = dat_line;
      if (mode == M_GLITCH && (i == 3 || i == 7)) begin
        repeat (10) @(negedge clk_clk);
        glitch = 1'b1;
        repeat (2) @(negedge clk_clk);
        glitch = 1'b0;
        repeat (28) @(negedge clk_clk);
      end else begin
        repeat (40) @(negedge clk_clk);
      end
    end
    if (mode != M_NACK) dev_dat_low = 1'b1;
    repeat (10) @(negedge clk_clk);
    dev_clk_low = 1'b1;
    repeat (40) @(negedge clk_clk);
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk_clk);
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_result(input int d0, input int e0, output bit timed_out);
    int t;
    t = 0;
    while (done_cnt == d0 && err_cnt == e0 && t < 20000) begin @(negedge clk_clk); t++; end
    timed_out = (t >= 20000);
    repeat (30) @(negedge clk_clk);
  endtask

  task automatic test_reset();
    reset_reset_n = 1'b0;
    repeat (4) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    checks++;
    if (tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", tx_ready);
    end
    checks++;
    if ({tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_outputs got busy,done,err,clk_oe,dat_oe=%b exp=00000",
               {tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe});
    end
  endtask

  task automatic test_enable();
    logic [10:0] fr;
    int inh, d0, e0;
    bit rts, to;
    exp_t e;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(CMD_ENABLE, 1, 0);
    device_receive(M_NORMAL, 0, fr, inh, rts);
    wait_result(d0, e0, to);
    e = exp_q.pop_front();
    checks++;
    if (inh < 120 || !rts) begin
      failures++;
      $display("FAIL enable_inhibit_rts got inhibit=%0d rts=%0b exp inhibit>=120 rts=1", inh, rts);
    end
    checks++;
    if (fr !== e.frame) begin
      failures++;
      $display("FAIL enable_frame got=%b exp=%b", fr, e.frame);
    end
    checks++;
    if (to || (done_cnt - d0) !== e.n_done || (err_cnt - e0) !== e.n_err) begin
      failures++;
      $display("FAIL enable_outcome got done=%0d err=%0d exp done=%0d err=%0d",
               done_cnt - d0, err_cnt - e0, e.n_done, e.n_err);
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL enable_ready_after got=%b exp=1", tx_ready);
    end
  endtask

  task automatic test_parity();
    logic [7:0] bytes [3];
    logic [10:0] fr;
    int inh, d0, e0;
    bit rts, to;
    exp_t e;
    bytes[0] = CMD_RESET;
    bytes[1] = 8'h00;
    bytes[2] = 8'h5A;
    for (int k = 0; k < 3; k++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      send_byte(bytes[k], 1, 0);
      device_receive(M_NORMAL, 0, fr, inh, rts);
      wait_result(d0, e0, to);
      e = exp_q.pop_front();
      checks++;
      if (fr !== e.frame) begin
        failures++;
        $display("FAIL parity_frame byte=%h got=%b exp=%b", bytes[k], fr, e.frame);
      end
      checks++;
      if (to || (done_cnt - d0) !== e.n_done || (err_cnt - e0) !== e.n_err) begin
        failures++;
        $display("FAIL parity_outcome byte=%h got done=%0d err=%0d exp done=%0d err=%0d",
                 bytes[k], done_cnt - d0, err_cnt - e0, e.n_done, e.n_err);
      end
    end
  endtask

  task automatic test_start_timeout();
    logic [10:0] fr;
    int inh, d0, e0, t;
    bit rts;
    exp_t e;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(CMD_RESET, 0, 1);
    device_receive(M_NOCLK, 0, fr, inh, rts);
    t = 0;
    while (err_cnt == e0 && t < 20000) begin @(negedge clk_clk); t++; end
    @(negedge clk_clk);
    e = exp_q.pop_front();
    checks++;
    if (!rts || t < 14950 || t > 15050) begin
      failures++;
      $display("FAIL start_timeout got rts=%0b cycles=%0d exp rts=1 cycles~15000", rts, t);
    end
    checks++;
    if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin
      failures++;
      $display("FAIL start_timeout_oe got=%b exp=00", {ps2_clk_oe, ps2_dat_oe});
    end
    checks++;
    if ((done_cnt - d0) !== e.n_done || (err_cnt - e0) !== e.n_err) begin
      failures++;
      $display("FAIL start_timeout_outcome got done=%0d err=%0d exp done=%0d err=%0d",
               done_cnt - d0, err_cnt - e0, e.n_done, e.n_err);
    end
  endtask

  task automatic test_nack();
    logic [10:0] fr;
    int inh, d0, e0;
    bit rts, to;
    exp_t e;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'hC3, 0, 1);
    device_receive(M_NACK, 0, fr, inh, rts);
    wait_result(d0, e0, to);
    e = exp_q.pop_front();
    checks++;
    if (fr !== e.frame) begin
      failures++;
      $display("FAIL nack_frame got=%b exp=%b", fr, e.frame);
    end
    checks++;
    if (to || (done_cnt - d0) !== e.n_done || (err_cnt - e0) !== e.n_err) begin
      failures++;
      $display("FAIL nack_outcome got done=%0d err=%0d exp done=%0d err=%0d",
               done_cnt - d0, err_cnt - e0, e.n_done, e.n_err);
    end
  endtask

  task automatic test_busy_ignore();
    logic [10:0] fr;
    int inh, d0, e0, c0;
    bit rts, to;
    exp_t e;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'h3C, 1, 0);
    fork
      device_receive(M_NORMAL, 0, fr, inh, rts);
      begin
        repeat (300) @(negedge clk_clk);
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        @(negedge clk_clk);
        tx_valid = 1'b0;
      end
    join
    wait_result(d0, e0, to);
    e = exp_q.pop_front();
    c0 = clk_oe_cnt;
    repeat (400) @(negedge clk_clk);
    checks++;
    if (fr !== e.frame) begin
      failures++;
      $display("FAIL busy_frame got=%b exp=%b", fr, e.frame);
    end
    checks++;
    if (to || (done_cnt - d0) !== e.n_done || (err_cnt - e0) !== e.n_err) begin
      failures++;
      $display("FAIL busy_outcome got done=%0d err=%0d exp done=%0d err=%0d",
               done_cnt - d0, err_cnt - e0, e.n_done, e.n_err);
    end
    checks++;
    if (clk_oe_cnt !== c0 || tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL busy_no_second_frame got extra_inhibit=%0d ready=%b exp 0 and 1",
               clk_oe_cnt - c0, tx_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] fr;
    logic [7:0] d;
    int inh, d0, e0;
    bit rts;
    exp_t e;
    d  = 8'hE5;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(d, 0, 0);
    device_receive(M_NORMAL, 5, fr, inh, rts);
    checks++;
    if (ps2_dat_oe !== ~d[4] || tx_busy !== 1'b1) begin
      failures++;
      $display("FAIL midreset_bit4_drive got dat_oe=%b busy=%b exp dat_oe=%b busy=1",
               ps2_dat_oe, tx_busy, ~d[4]);
    end
    #100;
    reset_reset_n = 1'b0;
    #1;
    checks++;
    if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin
      failures++;
      $display("FAIL midreset_oe_release got=%b exp=00", {ps2_clk_oe, ps2_dat_oe});
    end
    checks++;
    if ({tx_ready, tx_busy, tx_done, tx_error} !== 4'b1000) begin
      failures++;
      $display("FAIL midreset_status got ready,busy,done,err=%b exp=1000",
               {tx_ready, tx_busy, tx_done, tx_error});
    end
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (200) @(negedge clk_clk);
    e = exp_q.pop_front();
    checks++;
    if ((done_cnt - d0) !== e.n_done || (err_cnt - e0) !== e.n_err) begin
      failures++;
      $display("FAIL midreset_no_pulse got done=%0d err=%0d exp done=%0d err=%0d",
               done_cnt - d0, err_cnt - e0, e.n_done, e.n_err);
    end
    test_enable();
  endtask

  task automatic test_glitch();
    logic [10:0] fr;
    int inh, d0, e0;
    bit rts, to;
    exp_t e;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'h96, 1, 0);
    device_receive(M_GLITCH, 0, fr, inh, rts);
    wait_result(d0, e0, to);
    e = exp_q.pop_front();
    checks++;
    if (fr !== e.frame) begin
      failures++;
      $display("FAIL glitch_frame got=%b exp=%b", fr, e.frame);
    end
    checks++;
    if (to || (done_cnt - d0) !== e.n_done || (err_cnt - e0) !== e.n_err) begin
      failures++;
      $display("FAIL glitch_outcome got done=%0d err=%0d exp done=%0d err=%0d",
               done_cnt - d0, err_cnt - e0, e.n_done, e.n_err);
    end
  endtask

  initial begin
    test_reset();
    test_enable();
    test_parity();
    test_start_timeout();
    test_nack();
    test_busy_ignore();
    test_reset_mid();
    test_glitch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
